user_key_debouncer: RTL

USER_KEY_DEBOUNCER -- requirements
Module: user_key_debouncer

---
 rtl/key_db_pkg.sv | 18 +
 rtl/user_key_debouncer_if.sv | 11 +
 rtl/key_debounce_cell.sv | 85 ++++++++
 rtl/user_key_debouncer.sv | 90 +++++++++
 4 files changed

// File: rtl/key_db_pkg.sv
// rtl/key_db_pkg.sv - shared FSM encoding, register offsets and counter width for the key debouncer
package key_db_pkg;

    typedef enum logic [1:0] {
        ST_UP        = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_DOWN      = 2'd2,
        ST_REL_CHK   = 2'd3
    } key_state_e;

    localparam logic [1:0] REG_STATE = 2'd0;
    localparam logic [1:0] REG_EVENT = 2'd1;
    localparam logic [1:0] REG_MASK  = 2'd2;
    localparam logic [1:0] REG_RAW   = 2'd3;

    localparam int CNT_W = 20;

endpackage

// File: rtl/user_key_debouncer_if.sv
// rtl/user_key_debouncer_if.sv - register bus between the south bridge and the key debouncer
interface user_key_debouncer_if;
    logic [7:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, output WE, output Din, input Dout, input IRQ);
    modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/key_debounce_cell.sv
// rtl/key_debounce_cell.sv - one key: synchronizer, debounce FSM and counter, accept strobes
module key_debounce_cell
    import key_db_pkg::*;
#(
    parameter int DB_CYCLES   = 250000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic sync,
    output logic level,
    output logic press_evt,
    output logic release_evt
);

    // The counter starts at 0 on the first stable cycle, so the final stable cycle sees DB_CYCLES-2.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 2);

    logic [SYNC_STAGES-1:0] sync_ff;
    key_state_e             st;
    logic [CNT_W-1:0]       cnt;
    logic                   at_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], key_n};
        end
    end

    assign sync        = ~sync_ff[SYNC_STAGES-1];
    assign at_last     = (cnt == LAST);
    assign press_evt   = (st == ST_PRESS_CHK) && sync && at_last;
    assign release_evt = (st == ST_REL_CHK) && !sync && at_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= ST_UP;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            case (st)
                ST_UP: begin
                    cnt <= '0;
                    if (sync) st <= ST_PRESS_CHK;
                end
                ST_PRESS_CHK: begin
                    if (!sync) begin
                        st  <= ST_UP;
                        cnt <= '0;
                    end else if (at_last) begin
                        st    <= ST_DOWN;
                        cnt   <= '0;
                        level <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DOWN: begin
                    cnt <= '0;
                    if (!sync) st <= ST_REL_CHK;
                end
                ST_REL_CHK: begin
                    if (sync) begin
                        st  <= ST_DOWN;
                        cnt <= '0;
                    end else if (at_last) begin
                        st    <= ST_UP;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    st  <= ST_UP;
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/user_key_debouncer.sv
// rtl/user_key_debouncer.sv - 8-key debouncer with STATE/EVENT/MASK/RAW registers and IRQ
// Optional feature: KEY_RELEASE_EVT_EN adds release events in EVENT[15:8].
module user_key_debouncer
    import key_db_pkg::*;
#(
    parameter int DB_CYCLES   = 250000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 user_key,
    user_key_debouncer_if.slave        bus
);

    logic [7:0]  sync_vec;
    logic [7:0]  state_vec;
    logic [7:0]  press_vec;
    logic [7:0]  rel_vec;
    logic [7:0]  ev_press;
    logic [7:0]  ev_rel;
    logic [7:0]  mask;
    logic        irq;
    logic [1:0]  offset;
    logic        wr_event;
    logic        wr_mask;
    logic [31:0] dout;

    for (genvar k = 0; k < 8; k++) begin : g_key
        key_debounce_cell #(
            .DB_CYCLES   (DB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cell (
            .clk         (clk),
            .reset       (reset),
            .key_n       (user_key[k]),
            .sync        (sync_vec[k]),
            .level       (state_vec[k]),
            .press_evt   (press_vec[k]),
            .release_evt (rel_vec[k])
        );
    end

    assign offset   = bus.Addr[3:2];
    assign wr_event = bus.WE && (offset == REG_EVENT);
    assign wr_mask  = bus.WE && (offset == REG_MASK);

    // A new event is OR-ed in after the clear so it survives a same-cycle W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_press <= '0;
            mask     <= '0;
            irq      <= 1'b0;
        end else begin
            ev_press <= (ev_press & ~(wr_event ? bus.Din[7:0] : 8'h00)) | press_vec;
            if (wr_mask) mask <= bus.Din[7:0];
            irq <= |((ev_press | ev_rel) & mask);
        end
    end

`ifdef KEY_RELEASE_EVT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_rel <= '0;
        end else begin
            ev_rel <= (ev_rel & ~(wr_event ? bus.Din[15:8] : 8'h00)) | rel_vec;
        end
    end

    wire unused_bits = ^{bus.Addr[7:4], bus.Addr[1:0], bus.Din[31:16]};
`else
    assign ev_rel = 8'h00;

    wire unused_bits = ^{bus.Addr[7:4], bus.Addr[1:0], bus.Din[31:8], rel_vec};
`endif

    always_comb begin
        dout = '0;
        case (offset)
            REG_STATE: dout[7:0]  = state_vec;
            REG_EVENT: dout[15:0] = {ev_rel, ev_press};
            REG_MASK:  dout[7:0]  = mask;
            REG_RAW:   dout[7:0]  = sync_vec;
            default:   dout       = '0;
        endcase
    end

    assign bus.Dout = dout;
    assign bus.IRQ  = irq;

endmodule
